// File: rtl/reg_dualrail_fifo.sv
// Dual-rail (f/t pair) register stage with a DEPTH-entry FIFO between two
// four-phase return-to-zero handshakes, plus sticky illegal-codeword detection.
module reg_dualrail_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       hab,
    input  logic [2*WIDTH-1:0]         in,
    output logic                       in_ack,
    output logic [2*WIDTH-1:0]         out,
    input  logic                       out_ack,
    output logic                       err,
    input  logic                       err_clr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {I_DATA, I_NULL} in_state_t;
    typedef enum logic {O_NULL, O_DATA} out_state_t;

    in_state_t          in_state_reg, in_state_next;
    out_state_t         out_state_reg, out_state_next;
    logic [2*WIDTH-1:0] out_reg, out_next;
    logic               err_reg, err_next;
    logic [CW-1:0]      count_reg, count_next;
    logic [PW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [WIDTH-1:0]   mem [DEPTH];

    logic [WIDTH-1:0]   pair_empty, pair_illegal, in_bits, head_bits;
    logic [2*WIDTH-1:0] head_enc;
    logic               word_complete, word_null, word_bad;
    logic               push, pop, err_set, full;

    // Per-pair classification and decode/encode between dual-rail and binary.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pair
            assign pair_empty[gi]     = ~in[2*gi] & ~in[2*gi+1];
            assign pair_illegal[gi]   =  in[2*gi] &  in[2*gi+1];
            assign in_bits[gi]        =  in[2*gi+1];
            assign head_enc[2*gi]     = ~head_bits[gi];
            assign head_enc[2*gi+1]   =  head_bits[gi];
        end
    endgenerate

    assign word_complete = ~|pair_empty & ~|pair_illegal;
    assign word_null     = &pair_empty;
    assign word_bad      = |pair_illegal & ~|pair_empty;
    assign full          = (count_reg == CW'(DEPTH));
    assign head_bits     = mem[rd_ptr_reg];

    // Input side: accept or reject a word, then wait for the spacer.
    always_comb begin
        in_state_next = in_state_reg;
        push          = 1'b0;
        err_set       = 1'b0;
        case (in_state_reg)
            I_DATA: begin
                if (hab && word_complete && !full) begin
                    push          = 1'b1;
                    in_state_next = I_NULL;
                end else if (hab && word_bad) begin
                    err_set       = 1'b1;
                    in_state_next = I_NULL;
                end
            end
            I_NULL: begin
                if (word_null) in_state_next = I_DATA;
            end
            default: in_state_next = I_DATA;
        endcase
    end

    // Output side: present the head word, release it once acknowledged.
    always_comb begin
        out_state_next = out_state_reg;
        out_next       = out_reg;
        pop            = 1'b0;
        case (out_state_reg)
            O_NULL: begin
                if (count_reg != '0 && !out_ack) begin
                    out_next       = head_enc;
                    out_state_next = O_DATA;
                end
            end
            O_DATA: begin
                if (out_ack) begin
                    pop            = 1'b1;
                    out_next       = '0;
                    out_state_next = O_NULL;
                end
            end
            default: begin
                out_next       = '0;
                out_state_next = O_NULL;
            end
        endcase
    end

    assign count_next = count_reg + CW'(push) - CW'(pop);
    assign err_next   = err_set | (err_reg & ~err_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_state_reg  <= I_DATA;
            out_state_reg <= O_NULL;
            out_reg       <= '0;
            err_reg       <= 1'b0;
            count_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
        end else begin
            in_state_reg  <= in_state_next;
            out_state_reg <= out_state_next;
            out_reg       <= out_next;
            err_reg       <= err_next;
            count_reg     <= count_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= in_bits;
    end

    assign in_ack = (in_state_reg == I_NULL);
    assign out    = out_reg;
    assign err    = err_reg;
    assign count  = count_reg;

endmodule
